// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the 5-stage integer pipeline: op_data flag
// indices, forwarding select encoding, hazard FSM states, scoreboard slot.
package cpu_ctrl_pkg;

    localparam int OPD_W         = 15;
    localparam int OPD_USES_IMM  = 0;
    localparam int OPD_USES_R1   = 1;
    localparam int OPD_USES_R2   = 2;
    localparam int OPD_USES_RD   = 3;
    localparam int OPD_IS_BRANCH = 4;
    localparam int OPD_IS_JUMP   = 5;
    localparam int OPD_IS_ALU    = 6;
    localparam int OPD_MEM_READ  = 7;
    localparam int OPD_MEM_WRITE = 8;
    localparam int OPD_IS_CSR    = 9;
    localparam int OPD_IS_SYS    = 10;
    localparam int OPD_SIGNED    = 11;
    localparam int OPD_MEM1      = 12;
    localparam int OPD_MEM2      = 13;
    localparam int OPD_MEM4      = 14;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        REFILL  = 2'd2,
        MEMWAIT = 2'd3
    } hz_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } sb_slot_t;

    localparam sb_slot_t SLOT_EMPTY = '0;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding comparator: picks EX, MEM or register file for one
// source operand. Ports: used/rs of the operand, EX and MEM slots, sel out.
module fwd_select
    import cpu_ctrl_pkg::*;
(
    input  logic       used,
    input  logic [4:0] rs,
    input  sb_slot_t   ex_slot,
    input  sb_slot_t   mem_slot,
    output fwd_sel_t   sel
);

    always_comb begin
        sel = FWD_RF;
        if (used && rs != 5'd0) begin
            // A load in EX has no result yet; it is covered by the stall.
            if (ex_slot.valid && ex_slot.wr && !ex_slot.ld &&
                ex_slot.rd == rs) begin
                sel = FWD_EX;
            end else if (mem_slot.valid && mem_slot.wr &&
                         mem_slot.rd == rs) begin
                sel = FWD_MEM;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller beside decode: stall, bubble, flush, freeze,
// forwarding selects and a saturating lost-cycle counter.
// Ports: clk, reset_n, id_* decode info, ex_redirect, mem_busy in;
// stall, bubble, flush, freeze, fwd_a, fwd_b, lost_cycles out.
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REFILL_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [14:0]      id_op_data,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] lost_cycles
);

    sb_slot_t         ex_q, ex_d, mem_q, mem_d, id_slot;
    hz_state_t        state_q, state_d;
    logic [1:0]       refill_q, refill_d;
    logic             pend_redir_q, pend_redir_d;
    logic [CNT_W-1:0] lost_q, lost_d;

    logic     uses_r1, uses_r2, uses_rd, is_ld;
    logic     refill_act, id_eff, redir_eff, load_use;
    logic     stall_c, bubble_c, flush_c, freeze_c;
    fwd_sel_t sel_a, sel_b;
    logic     unused_opd;

    assign uses_r1 = id_op_data[OPD_USES_R1];
    assign uses_r2 = id_op_data[OPD_USES_R2];
    assign uses_rd = id_op_data[OPD_USES_RD];
    assign is_ld   = id_op_data[OPD_MEM_READ];
    assign unused_opd = ^{id_op_data[14:8], id_op_data[6:4], id_op_data[0]};

    assign id_slot.valid = 1'b1;
    assign id_slot.rd    = id_rd;
    assign id_slot.wr    = uses_rd && id_rd != 5'd0;
    assign id_slot.ld    = is_ld;

    // While refilling after a redirect, decode holds wrong-path garbage.
    assign refill_act = refill_q != 2'd0;
    assign id_eff     = id_valid && !refill_act;
    assign redir_eff  = ex_redirect || pend_redir_q;

    // ex_q.wr already excludes rd == 0, so x0 never matches.
    assign load_use = id_eff && ex_q.valid && ex_q.ld && ex_q.wr &&
                      ((uses_r1 && id_rs1 == ex_q.rd) ||
                       (uses_r2 && id_rs2 == ex_q.rd));

    fwd_select u_fwd_a (
        .used     (uses_r1),
        .rs       (id_rs1),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .sel      (sel_a)
    );

    fwd_select u_fwd_b (
        .used     (uses_r2),
        .rs       (id_rs2),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .sel      (sel_b)
    );

    always_comb begin
        stall_c      = 1'b0;
        bubble_c     = 1'b0;
        flush_c      = 1'b0;
        freeze_c     = 1'b0;
        state_d      = state_q;
        refill_d     = refill_q;
        pend_redir_d = pend_redir_q;
        ex_d         = ex_q;
        mem_d        = mem_q;
        lost_d       = lost_q;
        if (mem_busy) begin
            freeze_c     = 1'b1;
            stall_c      = 1'b1;
            state_d      = MEMWAIT;
            pend_redir_d = pend_redir_q || ex_redirect;
        end else begin
            pend_redir_d = 1'b0;
            if (redir_eff) begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                state_d  = REFILL;
                refill_d = 2'(REFILL_CYCLES);
            end else if (refill_act) begin
                refill_d = refill_q - 2'd1;
                state_d  = (refill_q == 2'd1) ? RUN : REFILL;
            end else if (load_use) begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                state_d  = LDSTALL;
            end else begin
                state_d  = RUN;
            end
            mem_d = ex_q;
            ex_d  = (bubble_c || !id_eff) ? SLOT_EMPTY : id_slot;
        end
        // Refill cycles are lost fetch slots too, so they count.
        if ((stall_c || flush_c || freeze_c || refill_act) &&
            lost_q != {CNT_W{1'b1}}) begin
            lost_d = lost_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            refill_q     <= 2'd0;
            pend_redir_q <= 1'b0;
            ex_q         <= SLOT_EMPTY;
            mem_q        <= SLOT_EMPTY;
            lost_q       <= '0;
        end else begin
            state_q      <= state_d;
            refill_q     <= refill_d;
            pend_redir_q <= pend_redir_d;
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            lost_q       <= lost_d;
        end
    end

    assign stall       = stall_c && reset_n;
    assign bubble      = bubble_c && reset_n;
    assign flush       = flush_c && reset_n;
    assign freeze      = freeze_c && reset_n;
    assign fwd_a       = reset_n ? sel_a : FWD_RF;
    assign fwd_b       = reset_n ? sel_b : FWD_RF;
    assign lost_cycles = lost_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (REFILL_CYCLES=2, CNT_W=4).
// Vector table drives decode/redirect/busy; expected outputs are queued.
module tb_pipeline_hazard_ctrl;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [14:0] id_op_data = '0;
    logic [4:0]  id_rs1 = '0;
    logic [4:0]  id_rs2 = '0;
    logic [4:0]  id_rd = '0;
    logic        ex_redirect = 1'b0;
    logic        mem_busy = 1'b0;
    logic        stall, bubble, flush, freeze;
    logic [1:0]  fwd_a, fwd_b;
    logic [3:0]  lost_cycles;
    logic [11:0] act;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REFILL_CYCLES (2),
        .CNT_W         (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .id_valid    (id_valid),
        .id_op_data  (id_op_data),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .ex_redirect (ex_redirect),
        .mem_busy    (mem_busy),
        .stall       (stall),
        .bubble      (bubble),
        .flush       (flush),
        .freeze      (freeze),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .lost_cycles (lost_cycles)
    );

    assign act = {stall, bubble, flush, freeze, fwd_a, fwd_b, lost_cycles};

    typedef struct {
        logic        vld, u1, u2, ud, ld;
        logic [4:0]  rs1, rs2, rd;
        logic        redir, busy;
        logic [11:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [11:0] exp_q[$];
    int          tag_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [11:0] ce;
    int          ct;

    task automatic chk(input string nm, input logic [11:0] a,
                       input logic [11:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got {st,bb,fl,fz,fa,fb,lost}=%b want %b",
                     nm, a, e);
        end
    endtask

    task automatic add(input int vld, u1, u2, ud, ld, rs1, rs2, rd,
                       input int redir, busy, st, bb, fl, fz, fa, fb,
                       input int lost);
        vec_t v;
        v.vld = 1'(vld); v.u1 = 1'(u1); v.u2 = 1'(u2);
        v.ud = 1'(ud); v.ld = 1'(ld);
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.redir = 1'(redir); v.busy = 1'(busy);
        v.exp = {1'(st), 1'(bb), 1'(fl), 1'(fz), 2'(fa), 2'(fb), 4'(lost)};
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.vld;
        id_op_data = '0;
        id_op_data[OPD_USES_R1] = v.u1;
        id_op_data[OPD_USES_R2] = v.u2;
        id_op_data[OPD_USES_RD] = v.ud;
        id_op_data[OPD_MEM_READ] = v.ld;
        id_rs1 = v.rs1;
        id_rs2 = v.rs2;
        id_rd = v.rd;
        ex_redirect = v.redir;
        mem_busy = v.busy;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            ct = tag_q.pop_front();
            chk($sformatf("vec%0d", ct), act, ce);
        end
    end

    initial begin
        // vld u1 u2 ud ld rs1 rs2 rd | redir busy | st bb fl fz fa fb lost
        // load-use: lw x5 ; add x6,x5,x1 (stall) ; add again (fwd MEM)
        add(1,1,0,1,1, 1,0,5,  0,0, 0,0,0,0, 0,0, 0);
        add(1,1,1,1,0, 5,1,6,  0,0, 1,1,0,0, 0,0, 0);
        add(1,1,1,1,0, 5,1,6,  0,0, 0,0,0,0, 2,0, 1);
        // back-to-back ALU, EX beats MEM
        add(1,1,0,1,0, 0,0,3,  0,0, 0,0,0,0, 0,0, 1);
        add(1,1,0,1,0, 3,0,3,  0,0, 0,0,0,0, 1,0, 1);
        add(1,1,1,1,0, 3,3,4,  0,0, 0,0,0,0, 1,1, 1);
        add(1,1,1,1,0, 3,4,8,  0,0, 0,0,0,0, 2,1, 1);
        // x0 destination, then unused rs2 is forced to RF
        add(1,1,0,1,0, 0,0,0,  0,0, 0,0,0,0, 0,0, 1);
        add(1,1,1,1,0, 0,0,7,  0,0, 0,0,0,0, 0,0, 1);
        add(1,1,0,1,0, 7,7,9,  0,0, 0,0,0,0, 1,0, 1);
        // redirect, two refill cycles ignore a lw x11
        add(1,1,0,1,1, 0,0,10, 1,0, 0,1,1,0, 0,0, 1);
        add(1,1,0,1,1, 0,0,11, 0,0, 0,0,0,0, 0,0, 2);
        add(1,1,1,1,0, 11,0,12,0,0, 0,0,0,0, 0,0, 3);
        add(1,1,1,1,0, 11,0,12,0,0, 0,0,0,0, 0,0, 4);
        // mem_busy 4 cycles, redirect in cycle 2, flush on cycle 5
        add(1,1,0,1,0, 12,0,13,0,1, 1,0,0,1, 1,0, 4);
        add(1,1,0,1,0, 12,0,13,1,1, 1,0,0,1, 1,0, 5);
        add(1,1,0,1,0, 12,0,13,0,1, 1,0,0,1, 1,0, 6);
        add(1,1,0,1,0, 12,0,13,0,1, 1,0,0,1, 1,0, 7);
        add(1,1,0,1,0, 12,0,13,0,0, 0,1,1,0, 1,0, 8);
        add(1,1,0,1,0, 0,0,13, 0,0, 0,0,0,0, 0,0, 9);
        add(1,1,0,1,0, 0,0,13, 0,0, 0,0,0,0, 0,0, 10);
        // redirect during REFILL restarts the refill
        add(1,1,0,1,0, 0,0,13, 1,0, 0,1,1,0, 0,0, 11);
        add(1,1,0,1,0, 0,0,13, 1,0, 0,1,1,0, 0,0, 12);
        add(1,1,0,1,0, 0,0,13, 0,0, 0,0,0,0, 0,0, 13);
        add(1,1,0,1,1, 1,0,5,  0,0, 0,0,0,0, 0,0, 14);
        add(1,1,1,1,0, 5,1,6,  0,0, 0,0,0,0, 0,0, 15);
        // load-use into a saturated counter, ends in LDSTALL
        add(1,1,0,1,1, 1,0,5,  0,0, 0,0,0,0, 0,0, 15);
        add(1,1,1,1,0, 5,1,6,  0,0, 1,1,0,0, 0,0, 15);
        add(1,1,1,1,0, 5,1,6,  0,0, 0,0,0,0, 2,0, 15);

        repeat (2) @(posedge clk);
        #1 chk("reset", act, 12'h000);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            exp_q.push_back(vecs[i].exp);
            tag_q.push_back(i);
        end
        @(negedge clk);
        #1;
        // still mid-LDSTALL here; drop reset between edges
        #1 reset_n = 1'b0;
        #1 chk("async_rst", act, 12'h000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(12'h000);
        tag_q.push_back(99);
        @(negedge clk);
        #1;
        chk("drain", 12'(exp_q.size()), 12'h000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
